// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad command sequencer, 27-bit add/sub/shift-add
// multiply, double-dabble BCD conversion and 8-digit display scanner.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   cmd[3:0]       0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 EQ, 14 CLR, 15 BKSP
//   cmd_valid      command offered; taken when cmd_valid && cmd_ready
//   cmd_ready      high in IDLE and ERR only
//   status[1:0]    00 BUSY, 01 ENTRY, 10 RESULT, 11 ERROR
//   data[3:0]      BCD digit at position (4'hE while in ERROR)
//   position[3:0]  scan index 0..7, bit 3 always 0
//
// Build option: define CALC_BKSP_EN to build the backspace (divide by 10)
// path; otherwise cmd 15 is accepted and ignored.

module calc_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [1:0] status,
  output logic [3:0] data,
  output logic [3:0] position
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALU, S_MUL, S_CONV, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_MUL
  } op_t;

  localparam logic [1:0]  ST_BUSY   = 2'b00;
  localparam logic [1:0]  ST_ENTRY  = 2'b01;
  localparam logic [1:0]  ST_RESULT = 2'b10;
  localparam logic [1:0]  ST_ERROR  = 2'b11;
  localparam logic [26:0] ENTRY_LIM = 27'd10_000_000;
  localparam logic [53:0] RES_MAX   = 54'd99_999_999;
  localparam logic [4:0]  LAST_IT   = 5'd26;

  state_t      state;
  op_t         op;
  op_t         pend_op;
  op_t         new_op;
  logic [26:0] entry;
  logic [26:0] acc;
  logic [26:0] shown;
  logic [31:0] bcd;
  logic [53:0] prod;
  logic [53:0] mcand;
  logic [26:0] mplier;
  logic [31:0] dd_bcd;
  logic [31:0] dd_adj;
  logic [31:0] dd_next;
  logic [26:0] dd_bin;
  logic [4:0]  cnt;
  logic        chain;
  logic        res_pend;

  logic        accept;
  logic        is_dig;
  logic        is_op;
  logic        is_eq;
  logic        is_clr;
  logic [26:0] entry_dig;
  logic [26:0] op_base;
  logic [53:0] alu_res;
  logic        alu_err;
`ifdef CALC_BKSP_EN
  logic        is_bksp;
  logic [26:0] entry_div;

  assign is_bksp   = cmd == 4'd15;
  assign entry_div = entry / 27'd10;
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign is_dig    = cmd <= 4'd9;
  assign is_op     = cmd >= 4'd10 && cmd <= 4'd12;
  assign is_eq     = cmd == 4'd13;
  assign is_clr    = cmd == 4'd14;
  assign entry_dig = entry * 27'd10 + {23'd0, cmd};
  // an operator pressed right after a result chains on that result
  assign op_base   = chain ? acc : entry;

  assign data = (status == ST_ERROR) ? 4'hE
              : bcd[{position[2:0], 2'b00} +: 4];

  always_comb begin
    new_op = OP_ADD;
    if (cmd == 4'd11) new_op = OP_SUB;
    else if (cmd == 4'd12) new_op = OP_MUL;
  end

  // SUB underflow wraps to a huge value, so the range check covers it
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = {27'd0, acc} + {27'd0, entry};
      OP_SUB:  alu_res = {27'd0, acc} - {27'd0, entry};
      OP_MUL:  alu_res = prod;
      default: alu_res = '0;
    endcase
    alu_err = alu_res > RES_MAX;
  end

  always_comb begin
    dd_adj = dd_bcd;
    for (int i = 0; i < 8; i++) begin
      if (dd_bcd[4*i +: 4] >= 4'd5)
        dd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
    end
    dd_next = {dd_adj[30:0], dd_bin[26]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      op        <= OP_NONE;
      pend_op   <= OP_NONE;
      entry     <= '0;
      acc       <= '0;
      shown     <= '0;
      bcd       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      dd_bcd    <= '0;
      dd_bin    <= '0;
      cnt       <= '0;
      chain     <= 1'b0;
      res_pend  <= 1'b0;
      cmd_ready <= 1'b1;
      status    <= ST_ENTRY;
      position  <= '0;
    end else begin
      position <= {1'b0, position[2:0] + 3'd1};
      if (accept && is_clr) begin
        state     <= S_IDLE;
        op        <= OP_NONE;
        pend_op   <= OP_NONE;
        entry     <= '0;
        acc       <= '0;
        shown     <= '0;
        bcd       <= '0;
        chain     <= 1'b0;
        res_pend  <= 1'b0;
        cmd_ready <= 1'b1;
        status    <= ST_ENTRY;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              unique case (1'b1)
                is_dig: begin
                  if (entry < ENTRY_LIM) begin
                    entry  <= entry_dig;
                    shown  <= entry_dig;
                    dd_bin <= entry_dig;
                  end else begin
                    shown  <= entry;
                    dd_bin <= entry;
                  end
                  chain     <= 1'b0;
                  res_pend  <= 1'b0;
                  dd_bcd    <= '0;
                  cnt       <= '0;
                  state     <= S_CONV;
                  cmd_ready <= 1'b0;
                  status    <= ST_BUSY;
                end
                is_op: begin
                  chain     <= 1'b0;
                  res_pend  <= 1'b0;
                  pend_op   <= new_op;
                  cnt       <= '0;
                  cmd_ready <= 1'b0;
                  status    <= ST_BUSY;
                  if (op == OP_NONE) begin
                    acc    <= op_base;
                    shown  <= op_base;
                    dd_bin <= op_base;
                    dd_bcd <= '0;
                    op     <= new_op;
                    entry  <= '0;
                    state  <= S_CONV;
                  end else if (op == OP_MUL) begin
                    prod   <= '0;
                    mcand  <= {27'd0, acc};
                    mplier <= entry;
                    state  <= S_MUL;
                  end else begin
                    state  <= S_ALU;
                  end
                end
                is_eq: begin
                  chain     <= 1'b0;
                  res_pend  <= 1'b1;
                  pend_op   <= OP_NONE;
                  cnt       <= '0;
                  cmd_ready <= 1'b0;
                  status    <= ST_BUSY;
                  if (op == OP_NONE) begin
                    shown  <= entry;
                    dd_bin <= entry;
                    dd_bcd <= '0;
                    state  <= S_CONV;
                  end else if (op == OP_MUL) begin
                    prod   <= '0;
                    mcand  <= {27'd0, acc};
                    mplier <= entry;
                    state  <= S_MUL;
                  end else begin
                    state  <= S_ALU;
                  end
                end
`ifdef CALC_BKSP_EN
                is_bksp: begin
                  entry     <= entry_div;
                  shown     <= entry_div;
                  dd_bin    <= entry_div;
                  dd_bcd    <= '0;
                  chain     <= 1'b0;
                  res_pend  <= 1'b0;
                  cnt       <= '0;
                  state     <= S_CONV;
                  cmd_ready <= 1'b0;
                  status    <= ST_BUSY;
                end
`endif
                default: ;
              endcase
            end
          end
          S_ALU: begin
            if (alu_err) begin
              state     <= S_ERR;
              cmd_ready <= 1'b1;
              status    <= ST_ERROR;
            end else begin
              acc    <= alu_res[26:0];
              shown  <= alu_res[26:0];
              dd_bin <= alu_res[26:0];
              dd_bcd <= '0;
              op     <= pend_op;
              entry  <= '0;
              // EQ leaves op empty; remember acc holds a usable result
              chain  <= pend_op == OP_NONE;
              cnt    <= '0;
              state  <= S_CONV;
            end
          end
          S_MUL: begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            // range check happens in S_ALU on the final product
            if (cnt == LAST_IT) state <= S_ALU;
          end
          S_CONV: begin
            dd_bcd <= dd_next;
            dd_bin <= dd_bin << 1;
            cnt    <= cnt + 5'd1;
            if (cnt == LAST_IT) begin
              bcd       <= dd_next;
              state     <= S_IDLE;
              cmd_ready <= 1'b1;
              status    <= res_pend ? ST_RESULT : ST_ENTRY;
            end
          end
          S_ERR: ;
          default: begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            status    <= ST_ENTRY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and random checks of calc_sequencer
// against a decimal-arithmetic model of the calculator.

module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] position;

  int total = 0;
  int bad   = 0;

  calc_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .status    (status),
    .data      (data),
    .position  (position)
  );

  always #5 clock = ~clock;

  // model state: values are plain decimal numbers
  bit     m_live = 1'b0;
  bit     m_chain;
  int     m_pos, m_busy, m_stat, m_fin, m_op;
  longint m_entry, m_acc, m_disp, m_pend;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_clr();
    m_entry = 0; m_acc = 0; m_op = 0; m_chain = 0;
    m_disp = 0; m_busy = 0; m_stat = 1;
  endtask

  task automatic m_start(input longint v, input int fin, input int n);
    m_pend = v; m_fin = fin; m_busy = n; m_stat = 0;
  endtask

  // nop: operator that follows (0 for EQ)
  task automatic m_arith(input int nop);
    longint r;
    int lat;
    lat = (m_op == 3) ? 28 : 1;
    case (m_op)
      1:       r = m_acc + m_entry;
      2:       r = m_acc - m_entry;
      default: r = m_acc * m_entry;
    endcase
    if (r < 0 || r > 99999999) begin
      m_busy = lat; m_fin = 3; m_stat = 0;
    end else begin
      m_acc = r; m_op = nop; m_entry = 0; m_chain = (nop == 0);
      m_start(r, (nop == 0) ? 2 : 1, lat + 27);
    end
  endtask

  task automatic m_cmd(input int c);
    if (m_stat == 3) begin
      if (c == 14) m_clr();
    end else if (c <= 9) begin
      if (m_entry < 10000000) m_entry = m_entry * 10 + c;
      m_chain = 0;
      m_start(m_entry, 1, 27);
    end else if (c <= 12) begin
      if (m_op == 0) begin
        if (!m_chain) m_acc = m_entry;
        m_chain = 0; m_op = c - 9; m_entry = 0;
        m_start(m_acc, 1, 27);
      end else m_arith(c - 9);
    end else if (c == 13) begin
      if (m_op == 0) begin
        m_chain = 0;
        m_start(m_entry, 2, 27);
      end else m_arith(0);
    end else if (c == 14) begin
      m_clr();
    end else begin
`ifdef CALC_BKSP_EN
      m_entry = m_entry / 10;
      m_chain = 0;
      m_start(m_entry, 1, 27);
`endif
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1'b1;
      m_clr();
      m_pos = 0;
    end else if (m_live) begin
      m_pos = (m_pos + 1) % 8;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_stat = m_fin;
          if (m_fin != 3) m_disp = m_pend;
        end
      end else if (cmd_valid) begin
        m_cmd(int'(cmd));
      end
    end
  end

  function automatic logic [3:0] exp_digit();
    longint v;
    v = m_disp;
    if (m_stat == 3) return 4'hE;
    for (int i = 0; i < m_pos; i++) v = v / 10;
    return 4'(v % 10);
  endfunction

  always @(negedge clock) begin
    if (m_live) begin
      chk("ready", 64'(cmd_ready), 64'(m_busy == 0));
      chk("status", 64'(status), 64'(m_stat));
      chk("position", 64'(position), 64'(m_pos));
      chk("data", 64'(data), 64'(exp_digit()));
    end
  end

  task automatic send(input logic [3:0] c);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: ready=0 after %0d cycles, expected 1", n);
    end
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_lat(output int cyc);
    cyc = 1;
    while (!cmd_ready && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // checks one full scan of the display against a literal BCD word
  task automatic check_disp(input string nm, input logic [31:0] v);
    for (int i = 0; i < 8; i++) begin
      chk(nm, 64'(data), 64'(v[4*m_pos +: 4]));
      @(negedge clock);
    end
  endtask

  initial begin
    int lat;
    int r;
    logic [31:0] bk;
    reset = 1'b1;
    cmd = '0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("scan_pos", 64'(position), 64'(i % 8));
      chk("scan_data0", 64'(data), 64'd0);
      chk("reset_status", 64'(status), 64'd1);
      chk("reset_ready", 64'(cmd_ready), 64'd1);
      @(negedge clock);
    end

    // 123 + 45 = 168
    send(4'd1); send(4'd2); send(4'd3); send(4'd10);
    send(4'd4); send(4'd5); send(4'd13);
    wait_lat(lat);
    chk("eq_add_lat", 64'(lat), 64'd29);
    chk("eq_add_status", 64'(status), 64'd2);
    chk("model_168", 64'(m_disp), 64'd168);
    check_disp("disp_168", 32'h0000_0168);

    // 9999 * 9999 = 99980001
    send(4'd14);
    for (int i = 0; i < 4; i++) send(4'd9);
    send(4'd12);
    for (int i = 0; i < 4; i++) send(4'd9);
    send(4'd13);
    wait_lat(lat);
    chk("eq_mul_lat", 64'(lat), 64'd56);
    chk("eq_mul_status", 64'(status), 64'd2);
    check_disp("disp_mul", 32'h9998_0001);

    // 5 - 7 underflows
    send(4'd14);
    send(4'd5); send(4'd11); send(4'd7); send(4'd13);
    wait_lat(lat);
    chk("err_lat", 64'(lat), 64'd2);
    chk("err_status", 64'(status), 64'd3);
    check_disp("disp_err", 32'hEEEE_EEEE);
    send(4'd3);
    chk("err_hold", 64'(status), 64'd3);
    chk("err_ready", 64'(cmd_ready), 64'd1);
    send(4'd14);
    chk("clr_status", 64'(status), 64'd1);
    check_disp("disp_clr", 32'h0);

    // nine 9s: the ninth is dropped
    for (int i = 0; i < 9; i++) send(4'd9);
    wait_lat(lat);
    check_disp("disp_9s", 32'h9999_9999);
    send(4'd15);
    wait_lat(lat);
`ifdef CALC_BKSP_EN
    bk = 32'h0999_9999;
`else
    bk = 32'h9999_9999;
`endif
    check_disp("disp_bksp", bk);

    // reset in the middle of a multiply
    send(4'd14);
    send(4'd3); send(4'd12); send(4'd4);
    wait_lat(lat);
    send(4'd13);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_ready", 64'(cmd_ready), 64'd1);
    chk("mid_status", 64'(status), 64'd1);
    chk("mid_pos", 64'(position), 64'd0);
    chk("mid_data", 64'(data), 64'd0);
    check_disp("mid_disp", 32'h0);
    repeat (60) @(negedge clock);
    chk("mid_quiet", 64'(status), 64'd1);

    // random traffic, including offers while busy and stray resets
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      if (r < 55) cmd = 4'($urandom_range(0, 9));
      else if (r < 65) cmd = 4'd10;
      else if (r < 72) cmd = 4'd11;
      else if (r < 78) cmd = 4'd12;
      else if (r < 88) cmd = 4'd13;
      else if (r < 93) cmd = 4'd14;
      else cmd = 4'd15;
      @(negedge clock);
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
